// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input front end: scancodes, key-state and
// joystick bit layouts, player/button limits and the coin pulser state type.
package arcade_input_pkg;

    localparam int MAX_PLAYERS = 4;
    localparam int MAX_BTN     = 8;
    localparam int KBD_BTN     = 4;

    // Per-player keyboard key-state layout
    localparam int KB_R     = 0;
    localparam int KB_L     = 1;
    localparam int KB_D     = 2;
    localparam int KB_U     = 3;
    localparam int KB_BTN0  = 4;
    localparam int KB_START = 8;
    localparam int KB_COIN  = 9;
    localparam int KB_BITS  = 10;

    // Per-player joystick word layout (start/coin follow the NBTN buttons)
    localparam int JOY_R    = 0;
    localparam int JOY_L    = 1;
    localparam int JOY_D    = 2;
    localparam int JOY_U    = 3;
    localparam int JOY_BTN0 = 4;
    localparam int JOY_W    = 32;

    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_P1_B0  = 8'h29;
    localparam logic [7:0] SC_P1_B1  = 8'h14;
    localparam logic [7:0] SC_P1_B2  = 8'h11;
    localparam logic [7:0] SC_P1_B3  = 8'h12;
    localparam logic [7:0] SC_P2_U   = 8'h2D;
    localparam logic [7:0] SC_P2_D   = 8'h2B;
    localparam logic [7:0] SC_P2_L   = 8'h23;
    localparam logic [7:0] SC_P2_R   = 8'h34;
    localparam logic [7:0] SC_P2_B0  = 8'h1C;
    localparam logic [7:0] SC_P2_B1  = 8'h1B;
    localparam logic [7:0] SC_P2_B2  = 8'h15;
    localparam logic [7:0] SC_P2_B3  = 8'h1D;
    localparam logic [7:0] SC_START1 = 8'h16;
    localparam logic [7:0] SC_START2 = 8'h1E;
    localparam logic [7:0] SC_START3 = 8'h26;
    localparam logic [7:0] SC_START4 = 8'h25;
    localparam logic [7:0] SC_COIN1  = 8'h2E;
    localparam logic [7:0] SC_COIN2  = 8'h36;
    localparam logic [7:0] SC_COIN3  = 8'h3D;
    localparam logic [7:0] SC_COIN4  = 8'h3E;
    localparam logic [7:0] SC_F1     = 8'h05;
    localparam logic [7:0] SC_F2     = 8'h06;

    typedef enum logic {
        CP_IDLE  = 1'b0,
        CP_PULSE = 1'b1
    } coin_state_e;

    // Key-state bits that may be written: keyboard buttons beyond nbtn are dropped
    function automatic logic [KB_BITS-1:0] key_mask(input int nbtn);
        logic [KB_BITS-1:0] m;
        m = '1;
        for (int b = 0; b < KBD_BTN; b++) begin
            if (b >= nbtn) m[KB_BTN0+b] = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_pulser.sv
// One coin slot: turns rising edges of a coin request into fixed-length pulses,
// remembering at most one edge that arrives while a pulse is running.
module coin_pulser
    import arcade_input_pkg::*;
#(
    parameter int COIN_CYC = 480000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output coin_state_e state_o
);

    localparam int CW = $clog2(COIN_CYC + 1);

    coin_state_e state_q;
    logic [CW-1:0] cnt_q;
    logic          pend_q;
    logic          req_prev_q;
    logic          rise;

    assign rise    = req_i & ~req_prev_q;
    assign state_o = state_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= CP_IDLE;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            req_prev_q <= 1'b0;
        end else begin
            req_prev_q <= req_i;
            case (state_q)
                CP_IDLE: begin
                    // A pending edge is served after exactly one idle cycle
                    if (rise || pend_q) begin
                        state_q <= CP_PULSE;
                        cnt_q   <= CW'(COIN_CYC - 1);
                        pend_q  <= 1'b0;
                    end
                end
                CP_PULSE: begin
                    if (rise) pend_q <= 1'b1;
                    if (cnt_q == '0) state_q <= CP_IDLE;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                default: state_q <= CP_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// Player-input front end: merges PS/2 key states and HPS joysticks into
// per-player direction/button/start/coin vectors with autofire and coin pulses.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int NPLAYERS   = 2,
    parameter int NBTN       = 2,
    parameter int COIN_CYC   = 480000,
    parameter int AF_HALF    = 1200000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic [10:0]              ps2_key,
    input  logic [NPLAYERS*32-1:0]   joystick,
    input  logic                     kbd_clear,
    input  logic                     cabinet,
    input  logic [NPLAYERS-1:0]      af_en,
    output logic [NPLAYERS*4-1:0]    dir,
    output logic [NPLAYERS*NBTN-1:0] btn,
    output logic [NPLAYERS-1:0]      start,
    output logic [NPLAYERS-1:0]      coin
);

    localparam logic [KB_BITS-1:0] KEY_MASK = key_mask(NBTN);
    localparam int   AW  = $clog2(AF_HALF + 1);
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [MAX_PLAYERS-1:0][KB_BITS-1:0] hit;
    logic [NPLAYERS-1:0][KB_BITS-1:0]    key_q;
    logic [NPLAYERS-1:0][MAX_BTN-1:0]    kbtn;
    logic                                tog_q;
    logic                                kbd_evt;
    logic [NPLAYERS-1:0][3:0]            dir_m, dir_q;
    logic [NPLAYERS-1:0][NBTN-1:0]       btn_m, btn_af, btn_q;
    logic [NPLAYERS-1:0]                 start_m, start_q, coin_m, coin_req_q, coin_act;
    logic [AW-1:0]                       af_cnt_q;
    logic                                af_phase_q;
    logic                                unused_bits;

    assign kbd_evt     = ps2_key[10] ^ tog_q;
    assign unused_bits = ^{hit, joystick};

    // Arrow codes match with or without the extended prefix; all others need bit 8 clear
    always_comb begin
        hit = '0;
        case (ps2_key[7:0])
            SC_UP:    hit[0][KB_U] = 1'b1;
            SC_DOWN:  hit[0][KB_D] = 1'b1;
            SC_LEFT:  hit[0][KB_L] = 1'b1;
            SC_RIGHT: hit[0][KB_R] = 1'b1;
            default:  ;
        endcase
        if (!ps2_key[8]) begin
            case (ps2_key[7:0])
                SC_P1_B0:  hit[0][KB_BTN0]   = 1'b1;
                SC_P1_B1:  hit[0][KB_BTN0+1] = 1'b1;
                SC_P1_B2:  hit[0][KB_BTN0+2] = 1'b1;
                SC_P1_B3:  hit[0][KB_BTN0+3] = 1'b1;
                SC_P2_U:   hit[1][KB_U]      = 1'b1;
                SC_P2_D:   hit[1][KB_D]      = 1'b1;
                SC_P2_L:   hit[1][KB_L]      = 1'b1;
                SC_P2_R:   hit[1][KB_R]      = 1'b1;
                SC_P2_B0:  hit[1][KB_BTN0]   = 1'b1;
                SC_P2_B1:  hit[1][KB_BTN0+1] = 1'b1;
                SC_P2_B2:  hit[1][KB_BTN0+2] = 1'b1;
                SC_P2_B3:  hit[1][KB_BTN0+3] = 1'b1;
                SC_START1: hit[0][KB_START]  = 1'b1;
                SC_START2: hit[1][KB_START]  = 1'b1;
                SC_START3: hit[2][KB_START]  = 1'b1;
                SC_START4: hit[3][KB_START]  = 1'b1;
                SC_COIN1:  hit[0][KB_COIN]   = 1'b1;
                SC_COIN2:  hit[1][KB_COIN]   = 1'b1;
                SC_COIN3:  hit[2][KB_COIN]   = 1'b1;
                SC_COIN4:  hit[3][KB_COIN]   = 1'b1;
                SC_F1: begin
                    hit[0][KB_START] = 1'b1;
                    hit[0][KB_COIN]  = 1'b1;
                end
                SC_F2: begin
                    hit[1][KB_START] = 1'b1;
                    hit[1][KB_COIN]  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tog_q <= 1'b0;
            key_q <= '0;
        end else begin
            tog_q <= ps2_key[10];
            if (kbd_clear) begin
                key_q <= '0;
            end else if (kbd_evt) begin
                for (int p = 0; p < NPLAYERS; p++) begin
                    for (int b = 0; b < KB_BITS; b++) begin
                        if (hit[p][b] && KEY_MASK[b]) key_q[p][b] <= ps2_key[9];
                    end
                end
            end
        end
    end

    always_comb begin
        kbtn    = '0;
        dir_m   = '0;
        btn_m   = '0;
        start_m = '0;
        coin_m  = '0;
        for (int p = 0; p < NPLAYERS; p++) begin
            kbtn[p][KBD_BTN-1:0] = key_q[p][KB_BTN0 +: KBD_BTN];
            dir_m[p] = {joystick[p*JOY_W+JOY_L] | key_q[p][KB_L],
                        joystick[p*JOY_W+JOY_R] | key_q[p][KB_R],
                        joystick[p*JOY_W+JOY_U] | key_q[p][KB_U],
                        joystick[p*JOY_W+JOY_D] | key_q[p][KB_D]};
            for (int b = 0; b < NBTN; b++) begin
                btn_m[p][b] = joystick[p*JOY_W+JOY_BTN0+b] | kbtn[p][b];
            end
            start_m[p] = joystick[p*JOY_W+JOY_BTN0+NBTN]   | key_q[p][KB_START];
            coin_m[p]  = joystick[p*JOY_W+JOY_BTN0+NBTN+1] | key_q[p][KB_COIN];
        end
        // Upright cabinet: any player's controls also steer player 1
        if (!cabinet) begin
            for (int p = 1; p < NPLAYERS; p++) begin
                dir_m[0] = dir_m[0] | dir_m[p];
                btn_m[0] = btn_m[0] | btn_m[p];
            end
        end
    end

    always_comb begin
        btn_af = btn_m;
        for (int p = 0; p < NPLAYERS; p++) begin
            if (af_en[p]) btn_af[p][0] = btn_m[p][0] & af_phase_q;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            af_cnt_q   <= '0;
            af_phase_q <= 1'b0;
            dir_q      <= '0;
            btn_q      <= '0;
            start_q    <= '0;
            coin_req_q <= '0;
        end else begin
            if (af_cnt_q == AW'(AF_HALF - 1)) begin
                af_cnt_q   <= '0;
                af_phase_q <= ~af_phase_q;
            end else begin
                af_cnt_q <= af_cnt_q + 1'b1;
            end
            dir_q      <= dir_m;
            btn_q      <= btn_af;
            start_q    <= start_m;
            coin_req_q <= coin_m;
        end
    end

    for (genvar p = 0; p < NPLAYERS; p++) begin : g_coin
        coin_state_e slot_state;
        coin_pulser #(.COIN_CYC(COIN_CYC)) u_coin (
            .clk_i   (clk_sys),
            .rst_i   (reset),
            .req_i   (coin_req_q[p]),
            .state_o (slot_state)
        );
        assign coin_act[p] = (slot_state == CP_PULSE);
    end

    assign dir   = dir_q   ^ {(NPLAYERS*4){INV}};
    assign btn   = btn_q   ^ {(NPLAYERS*NBTN){INV}};
    assign start = start_q ^ {NPLAYERS{INV}};
    assign coin  = coin_act ^ {NPLAYERS{INV}};

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper with 2 players, 2 buttons, 4-cycle
// coin pulses and a 3-cycle autofire half-period; outputs are active-low.
module tb_arcade_input_mapper;

    logic        clk_sys;
    logic        reset;
    logic [10:0] ps2_key;
    logic [63:0] joystick;
    logic        kbd_clear;
    logic        cabinet;
    logic [1:0]  af_en;
    logic [7:0]  dir;
    logic [3:0]  btn;
    logic [1:0]  start;
    logic [1:0]  coin;

    int   n_checks;
    int   n_errors;
    logic tog;

    arcade_input_mapper #(
        .NPLAYERS(2), .NBTN(2), .COIN_CYC(4), .AF_HALF(3), .ACTIVE_LOW(1)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_key   (ps2_key),
        .joystick  (joystick),
        .kbd_clear (kbd_clear),
        .cabinet   (cabinet),
        .af_en     (af_en),
        .dir       (dir),
        .btn       (btn),
        .start     (start),
        .coin      (coin)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
        tog     = ~tog;
        ps2_key = {tog, pressed, ext, code};
    endtask

    initial begin
        logic [19:0] vec;
        logic [15:0] pat;
        logic [11:0] af;
        int          bad;
        int          cnt;

        n_checks  = 0;
        n_errors  = 0;
        tog       = 1'b1;
        ps2_key   = 11'h400;
        joystick  = '0;
        kbd_clear = 1'b0;
        cabinet   = 1'b0;
        af_en     = 2'b00;
        reset     = 1'b1;
        tick(3);
        check_eq("reset_dir", dir, 8'hFF);
        check_eq("reset_btn", btn, 4'hF);
        check_eq("reset_start", start, 2'b11);
        check_eq("reset_coin", coin, 2'b11);
        reset = 1'b0;
        tick(3);

        // Keyboard P1 button 0: two-cycle latency, then release
        send_key(1'b1, 1'b0, 8'h29);
        tick(1);
        check_eq("kbd_b0_latency", btn, 4'hF);
        tick(1);
        check_eq("kbd_b0_press", btn, 4'hE);
        send_key(1'b0, 1'b0, 8'h29);
        tick(2);
        check_eq("kbd_b0_release", btn, 4'hF);

        // P1 button 2 exceeds NBTN and must not show anywhere
        send_key(1'b1, 1'b0, 8'h11);
        tick(2);
        check_eq("kbd_btn2_ignored", {dir, btn, start}, {8'hFF, 4'hF, 2'b11});
        send_key(1'b0, 1'b0, 8'h11);
        tick(2);

        // P2 up from keyboard, upright then cocktail
        cabinet = 1'b0;
        send_key(1'b1, 1'b0, 8'h2D);
        tick(2);
        check_eq("upright_p2_up", dir, 8'hDD);
        cabinet = 1'b1;
        tick(1);
        check_eq("cocktail_p2_up", dir, 8'hDF);
        send_key(1'b0, 1'b0, 8'h2D);
        tick(2);
        check_eq("p2_up_release", dir, 8'hFF);

        // Extended arrow, then kbd_clear pulse releases it
        send_key(1'b1, 1'b1, 8'h75);
        tick(2);
        check_eq("arrow_up", dir, 8'hFD);
        kbd_clear = 1'b1;
        tick(1);
        kbd_clear = 1'b0;
        tick(1);
        check_eq("kbd_clear_release", dir, 8'hFF);

        // Event coinciding with kbd_clear is consumed, never applied
        kbd_clear = 1'b1;
        send_key(1'b1, 1'b1, 8'h75);
        tick(1);
        kbd_clear = 1'b0;
        tick(3);
        check_eq("clear_wins", dir, 8'hFF);
        send_key(1'b0, 1'b1, 8'h75);
        tick(2);

        // Joystick path: one-cycle latency and cabinet merge
        cabinet = 1'b0;
        joystick[32] = 1'b1;
        tick(1);
        check_eq("joy_upright_p2_right", dir, 8'hBB);
        joystick = '0;
        cabinet  = 1'b1;
        joystick[37] = 1'b1;
        tick(1);
        check_eq("joy_cocktail_p2_b1", btn, 4'h7);
        joystick = '0;
        tick(2);

        // F2 = P2 start and coin; coin pulse starts one cycle after start
        send_key(1'b1, 1'b0, 8'h06);
        tick(2);
        check_eq("f2_start", start, 2'b01);
        check_eq("f2_coin_not_yet", coin, 2'b11);
        tick(1);
        check_eq("f2_coin_pulse", coin, 2'b01);
        send_key(1'b0, 1'b0, 8'h06);
        tick(6);
        check_eq("f2_done", {start, coin}, 4'hF);

        // Held coin request: a single 4-cycle pulse
        joystick[7] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            vec[i] = ~coin[0];
        end
        check_eq("coin_held_single", {12'h0, vec}, 32'h0001E);
        joystick[7] = 1'b0;
        tick(3);

        // Edges 2 cycles apart: pulse, one idle cycle, pulse; third edge dropped
        pat = 16'h0015;
        for (int i = 0; i < 16; i++) begin
            joystick[7] = pat[i];
            tick(1);
            vec[i] = ~coin[0];
        end
        check_eq("coin_pending", {16'h0, vec[15:0]}, 32'h03DE);
        joystick[7] = 1'b0;
        tick(3);

        // Autofire on P1 button 0: square wave with 3-cycle half-period
        af_en = 2'b01;
        joystick[4] = 1'b1;
        tick(1);
        for (int i = 0; i < 12; i++) begin
            tick(1);
            af[i] = ~btn[0];
        end
        bad = 0;
        cnt = 0;
        for (int i = 0; i < 9; i++) if (af[i] == af[i+3]) bad++;
        for (int i = 0; i < 12; i++) if (af[i]) cnt++;
        check_eq("af_half_period", bad, 0);
        check_eq("af_duty", cnt, 6);
        joystick[4] = 1'b0;
        tick(1);
        check_eq("af_release", btn[0], 1'b1);
        af_en = 2'b00;
        tick(2);

        // Asynchronous reset truncates a running pulse
        joystick[7] = 1'b1;
        tick(2);
        check_eq("rst_pulse_running", coin, 2'b10);
        #3;
        reset = 1'b1;
        #1;
        check_eq("rst_async_coin", coin, 2'b11);
        joystick[7] = 1'b0;
        tick(2);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (coin != 2'b11) cnt++;
        end
        check_eq("rst_no_pulse_after", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
